// File: rtl/stack_controller.sv
// Sequencer between the multi-cycle control unit and the stack memory.
// Owns the stack pointer, drives memory strobes and reports done/overflow/underflow.
module stack_controller #(
  parameter int DATA_W = 32,
  parameter int SP_W   = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic [DATA_W-1:0] push_data,
  input  logic              sp_clear,
  output logic [DATA_W-1:0] pop_data,
  output logic              done,
  output logic              busy,
  output logic              overflow,
  output logic              underflow,
  output logic              full,
  output logic              empty,
  output logic [SP_W-1:0]   mem_sp,
  output logic              mem_push,
  output logic              mem_pop,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  // Request handshake: push_req/pop_req/sp_clear are only looked at while
  // busy is low; done pulses once per completed request (success or error).

  localparam int PTR_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH_WR = 3'd1,
    POP_RD  = 3'd2,
    POP_CAP = 3'd3,
    ERR     = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PTR_W-1:0]  sp;
  logic [PTR_W-1:0]  sp_addr;
  logic [DATA_W-1:0] data_q;
  logic              err_is_ovf;
  logic              done_nxt;
  logic              ovf_nxt;
  logic              unf_nxt;

  assign full  = (sp == PTR_W'(DEPTH));
  assign empty = (sp == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (sp_clear) begin
          state_nxt = IDLE;
        end else if (push_req) begin
          state_nxt = full ? ERR : PUSH_WR;
        end else if (pop_req) begin
          state_nxt = empty ? ERR : POP_RD;
        end
      end
      PUSH_WR: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      POP_RD:  state_nxt = POP_CAP;
      POP_CAP: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      ERR: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        ovf_nxt   = err_is_ovf;
        unf_nxt   = ~err_is_ovf;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp         <= '0;
      data_q     <= '0;
      pop_data   <= '0;
      err_is_ovf <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      done      <= done_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
      case (state)
        IDLE: begin
          if (sp_clear) begin
            sp <= '0;
          end else if (push_req) begin
            // Error kind is remembered so ERR knows which flag to raise.
            err_is_ovf <= 1'b1;
            if (!full) data_q <= push_data;
          end else if (pop_req) begin
            err_is_ovf <= 1'b0;
          end
        end
        PUSH_WR: sp <= sp + PTR_W'(1);
        POP_CAP: begin
          pop_data <= mem_data_out;
          sp       <= sp - PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Pops address the top occupied slot, one below the next-free pointer.
  assign sp_addr     = (state == POP_RD || state == POP_CAP) ? sp - PTR_W'(1) : sp;
  assign mem_sp      = SP_W'(sp_addr);
  assign mem_push    = (state == PUSH_WR);
  assign mem_pop     = (state == POP_RD) || (state == POP_CAP);
  assign mem_data_in = data_q;
  assign busy        = (state != IDLE);

endmodule
